// File: rtl/change_dispenser.sv
// Greedy change-return pulse generator: turns a cents amount into a sequence of
// fixed-width dollar/quarter/dime/nickel eject pulses separated by idle gaps.
module change_dispenser #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] amount,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       do_out,
  output logic       q_out,
  output logic       di_out,
  output logic       n_out
);

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Coin lines packed as {dollar, quarter, dime, nickel}.
  logic [3:0]         lines_q, lines_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               amt_ok;
  logic [3:0]         sel_lines;
  logic [7:0]         sel_value;

  assign amt_ok = ((amount % 8'd5) == 8'd0);

  // Largest coin not exceeding the remainder; remainder is always a nonzero
  // multiple of 5 when this is consumed, so the nickel fallback never underflows.
  always_comb begin
    sel_lines = 4'b0001;
    sel_value = 8'd5;
    if (rem_q >= 8'd100) begin
      sel_lines = 4'b1000;
      sel_value = 8'd100;
    end else if (rem_q >= 8'd25) begin
      sel_lines = 4'b0100;
      sel_value = 8'd25;
    end else if (rem_q >= 8'd10) begin
      sel_lines = 4'b0010;
      sel_value = 8'd10;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (amt_ok) begin
            rem_d   = amount;
            busy_d  = 1'b1;
            state_d = SELECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SELECT: begin
        if (rem_q == 8'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = rem_q - sel_value;
          lines_d = sel_lines;
          cnt_d   = CNT_W'(PULSE_W);
          state_d = PULSE;
        end
      end

      PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          lines_d = 4'b0000;
          cnt_d   = CNT_W'(GAP_W);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        lines_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      cnt_q   <= '0;
      lines_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign do_out = lines_q[3];
  assign q_out  = lines_q[2];
  assign di_out = lines_q[1];
  assign n_out  = lines_q[0];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a timeline model derived from the greedy coin
// breakdown is compared against every output each cycle, plus pinned scenarios.
module tb_change_dispenser;

  localparam int PW   = 4;
  localparam int GW   = 4;
  localparam int SLOT = 1 + PW + GW;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] amount;
  logic       busy, done, err, do_out, q_out, di_out, n_out;

  change_dispenser #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .do_out (do_out),
    .q_out  (q_out),
    .di_out (di_out),
    .n_out  (n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc is the number of the cycle currently in progress; the edge that ends
  // cycle c-1 and starts cycle c is edge c-1.
  int cyc       = 0;
  int acc_k     = 0;
  int n_coins   = 0;
  int coins[16];           // 0=dollar 1=quarter 2=dime 3=nickel
  bit active    = 0;
  int err_cycle = -1;
  int free_edge = 0;

  always @(posedge clk) begin
    int e;
    int a;
    e = cyc;
    if (!rst_n) begin
      active    = 0;
      err_cycle = -1;
      free_edge = 0;
    end else if (load && e >= free_edge) begin
      if (int'(amount) % 5 == 0) begin
        int nd, nq, ndi, nn;
        a   = int'(amount);
        nd  = a / 100; a = a % 100;
        nq  = a / 25;  a = a % 25;
        ndi = a / 10;  a = a % 10;
        nn  = a / 5;
        n_coins = 0;
        for (int i = 0; i < nd;  i++) begin coins[n_coins] = 0; n_coins++; end
        for (int i = 0; i < nq;  i++) begin coins[n_coins] = 1; n_coins++; end
        for (int i = 0; i < ndi; i++) begin coins[n_coins] = 2; n_coins++; end
        for (int i = 0; i < nn;  i++) begin coins[n_coins] = 3; n_coins++; end
        acc_k     = e;
        active    = 1;
        free_edge = e + 3 + n_coins * SLOT;
      end else begin
        err_cycle = e + 1;
      end
    end
    cyc = e + 1;
  end

  // Expected {busy, done, err, do, q, di, n} for cycle c.
  function automatic logic [6:0] exp_out(input int c);
    logic [6:0] v;
    int d, span;
    v = 7'b0;
    if (c == err_cycle) v[4] = 1'b1;
    if (active) begin
      d    = c - acc_k;
      span = n_coins * SLOT;
      if (d >= 1 && d <= 1 + span) v[6] = 1'b1;
      if (d == 2 + span)           v[5] = 1'b1;
      if (d >= 2 && d <= 1 + span) begin
        if ((d - 2) % SLOT < PW) v[3 - coins[(d - 2) / SLOT]] = 1'b1;
      end
    end
    return v;
  endfunction

  // ---------------- compare / monitor ----------------
  string      obs_str  = "";
  int         done_cnt = 0;
  logic [3:0] prev_lines = 4'b0;

  always begin
    logic [6:0] act;
    logic [3:0] lines;
    @(negedge clk);
    #1;
    act   = {busy, done, err, do_out, q_out, di_out, n_out};
    lines = act[3:0];
    if (!rst_n) check($sformatf("reset_cycle%0d", cyc), {25'b0, act}, 32'b0);
    else        check($sformatf("model_cycle%0d", cyc), {25'b0, act}, {25'b0, exp_out(cyc)});
    check($sformatf("onehot_cycle%0d", cyc), {31'b0, ($countones(lines) <= 1)}, 32'd1);
    if (lines[3] && !prev_lines[3]) obs_str = {obs_str, "do "};
    if (lines[2] && !prev_lines[2]) obs_str = {obs_str, "q "};
    if (lines[1] && !prev_lines[1]) obs_str = {obs_str, "di "};
    if (lines[0] && !prev_lines[0]) obs_str = {obs_str, "n "};
    if (done) done_cnt++;
    prev_lines = lines;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int k, input string nm, input int exp_off);
    bit found;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    if (!found) check({nm, "_timeout"}, 32'd0, 32'd1);
    else        check({nm, "_done_off"}, 32'(cyc - k), 32'(exp_off));
  endtask

  // Issues a one-cycle load; returns the edge number that samples it.
  task automatic issue(input logic [7:0] amt, output int k);
    @(negedge clk);
    obs_str = "";
    k       = cyc;
    load    = 1'b1;
    amount  = amt;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic run_req(input logic [7:0] amt, input int exp_off,
                         input string exp_seq, input string nm);
    int k;
    issue(amt, k);
    check({nm, "_busy_k1"}, {31'b0, busy}, 32'd1);
    wait_done(k, nm, exp_off);
    check_str({nm, "_seq"}, obs_str, exp_seq);
    @(negedge clk);
    check({nm, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n  = 1'b0;
    load   = 1'b0;
    amount = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'b0, busy, done, err, do_out, q_out, di_out, n_out}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pinned scenarios.
    run_req(8'd65,  38, "q q di n ",          "amt65");
    run_req(8'd190, 56, "do q q q di n ",     "amt190");
    run_req(8'd0,    2, "",                   "amt0");
    run_req(8'd255, 47, "do do q q n ",       "amt255");

    // Rejected amount.
    issue(8'd7, k);
    check("amt7_err", {31'b0, err}, 32'd1);
    check("amt7_busy", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check_str("amt7_seq", obs_str, "");

    // Load held through a dispense: the second request waits for IDLE.
    @(negedge clk);
    obs_str = "";
    k       = cyc;
    load    = 1'b1;
    amount  = 8'd65;
    @(negedge clk);
    amount  = 8'd100;
    wait_done(k, "held1", 38);
    @(negedge clk);
    check("held_idle_gap", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("held_accept", {31'b0, busy}, 32'd1);
    load = 1'b0;
    wait_done(k + 39, "held2", 11);
    check_str("held_seq", obs_str, "q q di n do ");

    // Reset in the middle of the second pulse of 65.
    issue(8'd65, k);
    while (cyc < k + 12) @(negedge clk);
    check("mid_q_high", {31'b0, q_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {25'b0, busy, done, err, do_out, q_out, di_out, n_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    obs_str  = "";
    repeat (30) @(negedge clk);
    check("post_reset_done", 32'(done_cnt), 32'd0);
    check_str("post_reset_seq", obs_str, "");

    // Load presented together with reset release is taken at the first edge.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs_str = "";
    k       = cyc;
    rst_n   = 1'b1;
    load    = 1'b1;
    amount  = 8'd5;
    @(negedge clk);
    load = 1'b0;
    check("release_load_busy", {31'b0, busy}, 32'd1);
    wait_done(k, "release_load", 11);
    check_str("release_load_seq", obs_str, "n ");

    // Randomized traffic, including loads while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      load   = ($urandom_range(0, 3) == 0);
      amount = ($urandom_range(0, 2) != 0) ? 8'($urandom_range(0, 51) * 5)
                                           : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    load = 1'b0;
    repeat (80) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-return pulse generator for the vending-machine datapath: the outgoing counterpart of the coin-input synchronizers. Given a change amount in cents, it emits a greedy sequence of fixed-width, single-line coin-eject pulses (dollar, quarter, dime, nickel) toward the coin-return mechanism. It reports busy/done to the vending controller and rejects amounts that cannot be paid in nickels.

## Interface
Parameters:
- PULSE_W, 4: clocks each eject pulse is held high (≥1).
- GAP_W, 4: clocks all eject lines are held low between pulses (≥1).

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  request strobe; sampled only in IDLE.
- amount  input  8  change in cents, 0–255, sampled with load.
- busy  output  1  high while a request is being dispensed.
- done  output  1  one-cycle pulse when dispensing completes.
- err  output  1  one-cycle pulse when a load is rejected.
- do_out  output  1  dollar (100) eject pulse.
- q_out  output  1  quarter (25) eject pulse.
- di_out  output  1  dime (10) eject pulse.
- n_out  output  1  nickel (5) eject pulse.

## Operation
- Every output is registered. Under reset, all outputs are 0, the state is IDLE, and the remaining-amount register is 0.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE, load=1, amount%5==0: latch amount into remaining (8-bit), then go to SELECT with busy=1.
- IDLE, load=1, amount%5!=0: err=1 for one cycle and stay in IDLE. No coin is dispensed and busy stays 0.
- SELECT with remaining==0: go to DONE.
- SELECT otherwise: pick the largest coin ≤ remaining, checking 100, then 25, then 10, then 5. Subtract its value from remaining (no underflow is possible), load the width counter with PULSE_W, and go to PULSE.
- PULSE: only the selected coin line is high. After PULSE_W cycles, go to GAP.
- GAP: all coin lines are low. After GAP_W cycles, go to SELECT.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- load is ignored in every state except IDLE, including the DONE cycle. amount is not re-sampled while busy.
- At most one coin line is high in any cycle.

## Timing
- Let edge k be the clock edge at which load is sampled in IDLE.
- busy rises in cycle k+1. That cycle is SELECT.
- The first coin line is high during cycles k+2 .. k+1+PULSE_W.
- Each coin costs 1+PULSE_W+GAP_W cycles, made up of SELECT, PULSE and GAP.
- For N coins, done=1 in cycle k+2+N·(1+PULSE_W+GAP_W). busy falls in that same cycle.
- amount=0 gives N=0: done is high in cycle k+2, and no pulses are emitted.
- A rejected load gives err=1 in cycle k+1.
- The earliest next accepted load is sampled at the first edge after the DONE cycle.
- Reset asserted mid-operation forces all outputs to 0 immediately, without waiting for clk. Any in-flight pulse is truncated and the remaining coins are discarded. No done pulse follows.
- Reset release: the first load can be sampled at the first posedge after rst_n goes high.

## Test plan
- Defaults, load with amount=65: pulses q, q, di, n, each 4 cycles high with 4-cycle gaps. The first pulse starts at k+2. done is high at k+38 and busy is high for k+1..k+37.
- amount=190: pulse order do, q, q, q, di, n (6 coins). done is high at k+56. No two lines are ever high together.
- amount=0: no coin pulses, busy high only at k+1, done at k+2. amount=7: err at k+1, busy stays 0, no pulses.
- Second load asserted continuously during a 65-cent dispense with amount=100: it is ignored until IDLE. With load still held, the next accepted request is sampled at the edge after DONE and dispenses one do pulse.
- amount=255: pulses do, do, q, q, n. remaining reaches 0 with no wrap, and done is at k+47.
- rst_n dropped during the second pulse of 65: all outputs are 0 asynchronously. After release, outputs stay idle, with no done and no residual pulses, until a new load is sampled.
